// File: rtl/rv_ifetch.sv
// rv_ifetch: instruction fetch stage between the PC unit and decode.
//   - Takes fetch addresses from the PC unit (pc_i / pc_valid_i / pc_ready_o).
//   - Issues one instruction-memory request at a time (imem_req_o / imem_ack_i),
//     then waits for the response (imem_rvalid_i / imem_rdata_i).
//   - Buffers {pc, instr} pairs in a FIFO_DEPTH-entry FIFO whose head drives
//     decode (instr_valid_o / instr_o / instr_pc_o, popped by instr_ready_i).
//   - flush_i empties the FIFO and discards any response still in flight.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_i, pc_valid_i         fetch address and its valid
//   pc_ready_o               fetch address accepted this cycle
//   flush_i                  redirect
//   imem_req_o, imem_addr_o  memory request and address (held until ack)
//   imem_ack_i               memory accepted the request
//   imem_rvalid_i, imem_rdata_i  memory response
//   instr_valid_o, instr_o, instr_pc_o  FIFO head to decode
//   instr_ready_i            decode pops the head
module rv_ifetch #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pc_i,
    input  logic                   pc_valid_i,
    output logic                   pc_ready_o,
    input  logic                   flush_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   instr_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    input  logic                   instr_ready_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    kill_q, kill_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   pc_mem_q    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_mem_d    [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0]  instr_mem_q [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0]  instr_mem_d [FIFO_DEPTH];

    logic             push_now;
    logic             pop_now;
    logic             space_ok;
    logic             accept;
    logic [OCC_W-1:0] occ;

    // Handshake qualifiers
    always_comb begin
        push_now = (state_q == S_WAIT) && imem_rvalid_i && !kill_q && !flush_i;
        pop_now  = (count_q != '0) && instr_ready_i;
        // Reserve a slot for the response that will arrive for the new request;
        // pops are deliberately not credited here.
        occ      = OCC_W'(count_q) + OCC_W'(push_now);
        space_ok = occ < OCC_W'(FIFO_DEPTH);
        // Held low during reset so every output reads 0 while rst is asserted.
        pc_ready_o = !rst && !flush_i && space_ok &&
                     ((state_q == S_IDLE) || ((state_q == S_WAIT) && imem_rvalid_i));
        accept   = pc_valid_i && pc_ready_o;
    end

    // Request FSM next state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        kill_d  = kill_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_REQ;
                    addr_d  = pc_i;
                    kill_d  = 1'b0;
                end
            end
            S_REQ: begin
                // The request stays up through a flush; its response is dropped later.
                if (flush_i) kill_d = 1'b1;
                if (imem_ack_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    kill_d = 1'b0;
                    if (accept) begin
                        state_d = S_REQ;
                        addr_d  = pc_i;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO next state
    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_now) begin
                pc_mem_d[wr_ptr_q]    = addr_q;
                instr_mem_d[wr_ptr_q] = imem_rdata_i;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop_now) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_now, pop_now})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            kill_q      <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pc_mem_q    <= '{default: '0};
            instr_mem_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            kill_q      <= kill_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    always_comb begin
        imem_req_o    = (state_q == S_REQ);
        imem_addr_o   = addr_q;
        instr_valid_o = (count_q != '0);
        instr_o       = instr_mem_q[rd_ptr_q];
        instr_pc_o    = pc_mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_rv_ifetch.sv
// tb_rv_ifetch: directed bench for rv_ifetch with small PC-unit, memory and
// decode models. Inputs change on the falling edge; outputs are sampled there.
module tb_rv_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_ack_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [63:0] instr_pc_o;
    logic        instr_ready_i;

    rv_ifetch #(
        .ADDR_WIDTH (64),
        .INSTR_WIDTH(32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [63:0] pcq[$];
    logic [63:0] rx_pc[$];
    logic [31:0] rx_instr[$];

    int          ack_delay = 0;
    int          rv_delay  = 0;
    int          wait_cnt  = 0;
    int          resp_cnt  = 0;
    bit          resp_pending = 1'b0;
    logic [63:0] resp_addr = '0;
    int          req_cycles = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h0000_0013;
            64'h4:   return 32'h0010_0093;
            64'h8:   return 32'h0020_0113;
            default: return 32'hDEAD_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    task automatic drive();
        imem_rvalid_i = resp_pending && (resp_cnt >= rv_delay);
        imem_rdata_i  = imem_rvalid_i ? mem_word(resp_addr) : '0;
        imem_ack_i    = imem_req_o && (wait_cnt >= ack_delay);
        pc_valid_i    = (pcq.size() != 0);
        pc_i          = pc_valid_i ? pcq[0] : '0;
        #1;
    endtask

    task automatic step();
        bit          acc, pop, rv, ra, rq;
        logic [63:0] a, ppc;
        logic [31:0] pin;
        acc = pc_valid_i && pc_ready_o;
        pop = instr_valid_o && instr_ready_i;
        rv  = imem_rvalid_i;
        rq  = imem_req_o;
        ra  = imem_req_o && imem_ack_i;
        a   = imem_addr_o;
        ppc = instr_pc_o;
        pin = instr_o;
        if (rq) req_cycles++;
        @(posedge clk);
        if (rst) begin
            resp_pending = 1'b0;
            wait_cnt     = 0;
            resp_cnt     = 0;
        end else begin
            if (acc) void'(pcq.pop_front());
            if (pop) begin
                rx_pc.push_back(ppc);
                rx_instr.push_back(pin);
            end
            if (rv) resp_pending = 1'b0;
            else if (resp_pending) resp_cnt++;
            if (ra) begin
                resp_pending = 1'b1;
                resp_addr    = a;
                resp_cnt     = 0;
                wait_cnt     = 0;
            end else if (rq) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        drive();
        step();
    endtask

    task automatic run_until(input int n, input int bound, input string tag, output int used);
        used = 0;
        while (rx_pc.size() < n && used < bound) begin
            tick();
            used++;
        end
        check_eq(tag, 64'(rx_pc.size() >= n), 64'd1);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_req"},   64'(imem_req_o),    64'd0);
        check_eq({tag, "_addr"},  imem_addr_o,        64'd0);
        check_eq({tag, "_valid"}, 64'(instr_valid_o), 64'd0);
        check_eq({tag, "_instr"}, 64'(instr_o),       64'd0);
        check_eq({tag, "_ipc"},   instr_pc_o,         64'd0);
        check_eq({tag, "_ready"}, 64'(pc_ready_o),    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          used;
        logic [63:0] exp_pc[4];
        logic [31:0] exp_in[4];

        rst           = 1'b1;
        flush_i       = 1'b0;
        pc_i          = '0;
        pc_valid_i    = 1'b0;
        imem_ack_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b1;

        // Reset
        @(negedge clk);
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        drive();
        check_eq("idle_ready", 64'(pc_ready_o), 64'd1);

        // 1: basic fetch, 1 instruction per 2 cycles
        req_cycles = 0;
        pcq = '{64'h0, 64'h4, 64'h8};
        run_until(3, 30, "basic_timeout", used);
        check_eq("basic_cycles", 64'(used), 64'd8);
        check_eq("basic_reqs", 64'(req_cycles), 64'd3);
        exp_pc = '{64'h0, 64'h4, 64'h8, 64'h0};
        exp_in = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0};
        for (int i = 0; i < 3; i++) begin
            check_eq("basic_pc", rx_pc[i], exp_pc[i]);
            check_eq("basic_instr", 64'(rx_instr[i]), 64'(exp_in[i]));
        end
        settle(3);
        check_eq("basic_count", 64'(rx_pc.size()), 64'd3);
        rx_pc.delete();
        rx_instr.delete();

        // 2: backpressure fills exactly FIFO_DEPTH entries
        instr_ready_i = 1'b0;
        req_cycles    = 0;
        pcq = '{64'h10, 64'h14, 64'h18, 64'h1C};
        settle(10);
        check_eq("bp_valid", 64'(instr_valid_o), 64'd1);
        check_eq("bp_head_pc", instr_pc_o, 64'h10);
        check_eq("bp_head_instr", 64'(instr_o), 64'hDEAD_0010);
        check_eq("bp_pc_ready", 64'(pc_ready_o), 64'd0);
        check_eq("bp_req", 64'(imem_req_o), 64'd0);
        check_eq("bp_pending_pcs", 64'(pcq.size()), 64'd2);
        check_eq("bp_reqs", 64'(req_cycles), 64'd2);
        instr_ready_i = 1'b1;
        run_until(4, 40, "bp_timeout", used);
        settle(3);
        check_eq("bp_count", 64'(rx_pc.size()), 64'd4);
        exp_pc = '{64'h10, 64'h14, 64'h18, 64'h1C};
        exp_in = '{32'hDEAD_0010, 32'hDEAD_0014, 32'hDEAD_0018, 32'hDEAD_001C};
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_pc", rx_pc[i], exp_pc[i]);
            check_eq("bp_instr", 64'(rx_instr[i]), 64'(exp_in[i]));
        end
        rx_pc.delete();
        rx_instr.delete();

        // 3: flush while waiting for a response, with a buffered entry
        instr_ready_i = 1'b0;
        rv_delay      = 2;
        pcq = '{64'hF0, 64'h100};
        settle(6);
        check_eq("fw_pre_valid", 64'(instr_valid_o), 64'd1);
        check_eq("fw_pre_pc", instr_pc_o, 64'hF0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_eq("fw_empty", 64'(instr_valid_o), 64'd0);
        instr_ready_i = 1'b1;
        pcq.push_back(64'h200);
        run_until(1, 30, "fw_timeout", used);
        settle(4);
        check_eq("fw_count", 64'(rx_pc.size()), 64'd1);
        check_eq("fw_pc", rx_pc[0], 64'h200);
        check_eq("fw_instr", 64'(rx_instr[0]), 64'hDEAD_0200);
        rx_pc.delete();
        rx_instr.delete();
        rv_delay = 0;

        // 4: flush while the request waits 3 cycles for ack
        ack_delay = 3;
        pcq = '{64'h300};
        tick();
        check_eq("fr_req1", 64'(imem_req_o), 64'd1);
        check_eq("fr_addr1", imem_addr_o, 64'h300);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("fr_req_hold", 64'(imem_req_o), 64'd1);
            check_eq("fr_addr_hold", imem_addr_o, 64'h300);
            tick();
        end
        check_eq("fr_req_last", 64'(imem_req_o), 64'd1);
        tick();
        check_eq("fr_req_done", 64'(imem_req_o), 64'd0);
        tick();
        check_eq("fr_dropped", 64'(instr_valid_o), 64'd0);
        ack_delay = 0;
        pcq.push_back(64'h304);
        run_until(1, 30, "fr_timeout", used);
        settle(3);
        check_eq("fr_count", 64'(rx_pc.size()), 64'd1);
        check_eq("fr_pc", rx_pc[0], 64'h304);
        rx_pc.delete();
        rx_instr.delete();

        // 5a: flush in the same cycle as rvalid
        instr_ready_i = 1'b0;
        pcq = '{64'h400};
        settle(2);
        flush_i = 1'b1;
        pcq.push_back(64'h404);
        drive();
        check_eq("fs_rvalid_seen", 64'(imem_rvalid_i), 64'd1);
        check_eq("fs_pc_ready", 64'(pc_ready_o), 64'd0);
        step();
        flush_i = 1'b0;
        check_eq("fs_no_push", 64'(instr_valid_o), 64'd0);
        // 5b: push and pop together at count=1
        settle(3);
        check_eq("pp_pre_valid", 64'(instr_valid_o), 64'd1);
        check_eq("pp_pre_pc", instr_pc_o, 64'h404);
        pcq.push_back(64'h408);
        settle(2);
        instr_ready_i = 1'b1;
        tick();
        check_eq("pp_valid", 64'(instr_valid_o), 64'd1);
        check_eq("pp_pc", instr_pc_o, 64'h408);
        check_eq("pp_instr", 64'(instr_o), 64'hDEAD_0408);
        tick();
        check_eq("pp_drained", 64'(instr_valid_o), 64'd0);
        check_eq("pp_rx_count", 64'(rx_pc.size()), 64'd2);
        check_eq("pp_rx_pc", rx_pc[1], 64'h408);
        rx_pc.delete();
        rx_instr.delete();

        // 6: reset while waiting for a response
        rv_delay = 3;
        pcq = '{64'h500};
        settle(2);
        rst = 1'b1;
        tick();
        check_outputs_zero("rst_wait");
        tick();
        rst      = 1'b0;
        rv_delay = 0;
        rx_pc.delete();
        rx_instr.delete();
        pcq = '{64'h0};
        run_until(1, 30, "rst_timeout", used);
        settle(3);
        check_eq("rst_count", 64'(rx_pc.size()), 64'd1);
        check_eq("rst_pc", rx_pc[0], 64'h0);
        check_eq("rst_instr", 64'(rx_instr[0]), 64'h0000_0013);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_ifetch.md
Name: rv_ifetch

Overview:
Instruction fetch stage. It sits directly downstream of the program counter unit and upstream of decode.
- Accepts fetch addresses from the PC unit over a valid/ready handshake.
- Issues them to instruction memory over a req/ack plus rvalid interface, keeping one request outstanding at most.
- Buffers returned instructions, each tagged with its PC, in a small FIFO that drives decode.
- On a redirect (flush_i), drops all buffered and in-flight instructions.

Parameters:
ADDR_WIDTH, 64, width of PC and instruction memory address.
INSTR_WIDTH, 32, width of one instruction word.
FIFO_DEPTH, 2, number of {pc, instr} entries; power of two, at least 2.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
pc_i  input  ADDR_WIDTH  fetch address from PC unit
pc_valid_i  input  1  pc_i valid
pc_ready_o  output  1  pc_i accepted this cycle; PC unit advances only when pc_valid_i && pc_ready_o
flush_i  input  1  redirect; discard FIFO contents and any in-flight response
imem_req_o  output  1  memory request
imem_addr_o  output  ADDR_WIDTH  request address
imem_ack_i  input  1  memory accepted request
imem_rvalid_i  input  1  response valid
imem_rdata_i  input  INSTR_WIDTH  response instruction
instr_valid_o  output  1  FIFO head valid
instr_o  output  INSTR_WIDTH  FIFO head instruction
instr_pc_o  output  ADDR_WIDTH  FIFO head PC
instr_ready_i  input  1  decode pops head when instr_valid_o && instr_ready_i

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, FIFO count=0, read/write pointers=0, kill=0, addr_q=0.
  - All outputs are 0. Reset mid-request abandons the request; the bench must not drive rvalid for it after reset.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: imem_req_o=1, imem_addr_o=addr_q held stable.
  - WAIT: request accepted, waiting for imem_rvalid_i.
- Space check: space_ok = (count_q + push_now) < FIFO_DEPTH, where push_now=1 when a response is written this cycle. This guarantees the in-flight response always has a slot, so the FIFO never overflows.
- pc_ready_o is combinational: 1 iff !flush_i && space_ok && (state==IDLE || (state==WAIT && imem_rvalid_i)).
- On acceptance: addr_q<=pc_i, state<=REQ, kill<=0.
- IDLE: stays IDLE if no acceptance.
- REQ:
  - imem_ack_i=1 -> WAIT.
  - A request is never withdrawn once asserted, even on flush.
  - flush_i in REQ sets kill<=1; the request completes and its response is discarded.
- WAIT:
  - imem_rvalid_i=1 and !kill and !flush_i: push {addr_q, imem_rdata_i}.
  - imem_rvalid_i=1 and (kill or flush_i): discard the response.
  - After the response: -> REQ if a new PC is accepted the same cycle, else -> IDLE.
  - flush_i without rvalid sets kill<=1.
- Response timing: rvalid arrives at least 1 cycle after the ack cycle. rvalid outside WAIT is ignored.
- Throughput: 1 instruction per 2 cycles when memory acks and responds with 1-cycle latency.
- FIFO:
  - Head registered; instr_o and instr_pc_o are valid only when instr_valid_o=1.
  - Simultaneous push and pop leaves count unchanged.
  - Pop while empty is ignored.
- flush_i:
  - Next cycle: count=0, pointers=0, instr_valid_o=0.
  - A push in the flush cycle is suppressed.
  - pc_ready_o=0 in the flush cycle; the new PC is accepted from the next cycle.
  - flush_i in IDLE only clears the FIFO.
- Width rules: imem_addr_o = addr_q passed unmodified; low address bits are not checked.

Test Plan:
1. Basic fetch: pc 0x0,0x4,0x8 valid, ack same cycle, rvalid 1 cycle later, rdata 0x00000013/0x00100093/0x00200113, decode always ready -> instr_o/instr_pc_o emit (0x00000013,0x0), (0x00100093,0x4), (0x00200113,0x8) in order; imem_req_o high one cycle per fetch.
2. Backpressure: instr_ready_i=0 with FIFO_DEPTH=2 -> exactly 2 entries buffered, pc_ready_o=0 and imem_req_o=0 thereafter; release ready -> entries drain in order and fetching resumes with no loss or duplication.
3. Flush in WAIT: pc 0x100 acked, flush_i pulsed before rvalid, next pc 0x200 -> 0x100 response discarded, only 0x200 delivered, FIFO empty the cycle after flush.
4. Flush in REQ with ack delayed 3 cycles: imem_req_o and imem_addr_o stay stable until ack; that response is dropped; no instr_valid_o for it.
5. Flush in the same cycle as rvalid, and simultaneous push/pop at count=1 -> no push on flush; count remains 1 on push+pop.
6. Reset mid-WAIT: rst asserted -> all outputs 0 next cycle, state IDLE; fetch restarts cleanly from new pc 0x0.
